// File: rtl/muldiv_pkg.sv
// Shared op/read codes, FSM state type and default width for the multiply/divide unit.
// Also imported by the ALU control block to decode mult/div/mfhi/mflo.
package muldiv_pkg;

  localparam int MULDIV_WIDTH = 32;

  localparam logic [3:0] OP_MULT = 4'b1010;
  localparam logic [3:0] OP_DIV  = 4'b1111;
  localparam logic [3:0] OP_MFHI = 4'b0101;
  localparam logic [3:0] OP_MFLO = 4'b0111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the mul/div datapath: shift-add (mul) or trial-subtract/restore (div).
// Latency: purely combinational, zero cycles.
// Backpressure: none; the sequencer decides when the result is registered.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic                 div_mode,
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [WIDTH-1:0]     opnd,
  output logic [2*WIDTH-1:0]   acc_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] trial;

  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    // Partial remainder after the left shift is acc[2W-1:W-1]; borrow in the top bit means restore.
    trial    = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
    acc_next = '0;
    if (div_mode) begin
      if (!trial[WIDTH]) begin
        acc_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {acc[2*WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle mult/div unit with HI/LO; MULDIV_SIGNED_EN selects two's complement operands.
// Latency: done pulses WIDTH+2 cycles after acceptance (1 cycle for divide by zero).
// Backpressure: stall = busy & (rd_en | start); start while busy is dropped and must be held.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             rd_en,
  input  logic [3:0]       rd_sel,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  muldiv_state_t          state;
  logic [CW-1:0]          cnt;
  logic [2*WIDTH-1:0]     acc;
  logic [2*WIDTH-1:0]     acc_step;
  logic [2*WIDTH-1:0]     prod_fix;
  logic [WIDTH-1:0]       opnd;
  logic [WIDTH-1:0]       mag_a;
  logic [WIDTH-1:0]       mag_b;
  logic [WIDTH-1:0]       q_fix;
  logic [WIDTH-1:0]       r_fix;
  logic                   in_neg_a;
  logic                   in_neg_b;
  logic                   neg_a;
  logic                   neg_b;
  logic                   is_div;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div_mode (state == ST_DIV),
    .acc      (acc),
    .opnd     (opnd),
    .acc_next (acc_step)
  );

  always_comb begin
`ifdef MULDIV_SIGNED_EN
    in_neg_a = src_a[WIDTH-1];
    in_neg_b = src_b[WIDTH-1];
`else
    in_neg_a = 1'b0;
    in_neg_b = 1'b0;
`endif
    mag_a    = in_neg_a ? -src_a : src_a;
    mag_b    = in_neg_b ? -src_b : src_b;
    // Remainder follows the dividend's sign; quotient and product follow the sign XOR.
    prod_fix = (neg_a ^ neg_b) ? -acc : acc;
    q_fix    = (neg_a ^ neg_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    r_fix    = neg_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    rd_data = '0;
    if (rd_sel == OP_MFHI) begin
      rd_data = hi;
    end else if (rd_sel == OP_MFLO) begin
      rd_data = lo;
    end
  end

  assign stall = busy & (rd_en | start);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      is_div <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && op == OP_MULT) begin
            state  <= ST_MUL;
            busy   <= 1'b1;
            cnt    <= '0;
            acc    <= {{WIDTH{1'b0}}, mag_b};
            opnd   <= mag_a;
            neg_a  <= in_neg_a;
            neg_b  <= in_neg_b;
            is_div <= 1'b0;
          end else if (start && op == OP_DIV) begin
            busy <= 1'b1;
            if (src_b == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
              hi    <= src_a;
              lo    <= '1;
            end else begin
              state  <= ST_DIV;
              cnt    <= '0;
              acc    <= {{WIDTH{1'b0}}, mag_a};
              opnd   <= mag_b;
              neg_a  <= in_neg_a;
              neg_b  <= in_neg_b;
              is_div <= 1'b1;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          acc <= acc_step;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= ST_FIX;
          end
        end
        ST_FIX: begin
          state <= ST_DONE;
          done  <= 1'b1;
          if (is_div) begin
            hi <= r_fix;
            lo <= q_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle multiply/divide unit with its own HI/LO register pair, sequenced by a small FSM. Sits beside the main ALU in EX. Accepts `mult`/`div` commands using the ALU control codes (1010 mult, 1111 div), and serves `mfhi`/`mflo` reads (0101/0111). Stalls the pipeline while an operation is in flight.

## Interface
- `WIDTH`, default 32: operand and HI/LO width.
- `clk`  in  1: rising-edge clock.
- `reset_n`  in  1: asynchronous active-low reset.
- `start`  in  1: issue command on `op` this cycle.
- `op`  in  4: ALU control code; 1010 = mult, 1111 = div; any other code with `start` is ignored.
- `src_a`  in  WIDTH: multiplicand or dividend.
- `src_b`  in  WIDTH: multiplier or divisor.
- `rd_en`  in  1: EX holds an `mfhi`/`mflo`.
- `rd_sel`  in  4: 0101 selects HI, 0111 selects LO.
- `rd_data`  out  WIDTH: combinational HI or LO per `rd_sel`. Reads 0 for any other code.
- `busy`  out  1: operation in flight.
- `stall`  out  1: `busy & (rd_en | start)`.
- `done`  out  1: one-cycle pulse when HI/LO are updated.
- `hi`, `lo`  out  WIDTH: architectural HI/LO registers.

## Operation
- Reset values: `hi`, `lo` = 0; `busy`, `done` = 0; state IDLE; iteration counter 0.
- FSM states: IDLE, MUL, DIV, FIX, DONE.
  - IDLE -> MUL on `start & op==1010`.
  - IDLE -> DIV on `start & op==1111 & src_b!=0`.
  - IDLE -> DONE on `start & op==1111 & src_b==0`.
  - MUL/DIV -> FIX when the counter reaches WIDTH-1.
  - FIX -> DONE. DONE -> IDLE.
- Capture on acceptance: operand magnitudes and sign flags are latched. The counter is cleared.
- MUL: radix-2 shift-add, one bit per cycle, into a 2·WIDTH accumulator. At the end, HI = upper half and LO = lower half.
- DIV: restoring division, one quotient bit per cycle. LO = quotient, HI = remainder.
- FIX: applies sign correction and computes the final HI/LO values. HI and LO are written on the FIX->DONE edge.
- DONE: `done` = 1 for exactly one cycle.
- Divide by zero: no iterations. On the IDLE->DONE edge, LO = all ones and HI = `src_a`.
- `start` while `busy`: ignored. Upstream must hold the instruction under `stall`, and it is re-accepted in IDLE.
- `rd_data` during `busy` shows the old HI/LO values. It is not valid for the pipeline because `stall` is high.
- Reset mid-operation: returns to IDLE immediately. HI and LO clear to 0, and no `done` is issued.

## Timing
- Start accepted at edge E0.
- MUL/DIV run edges E1..E32 (WIDTH iterations).
- FIX at E33 writes HI/LO. DONE occupies the cycle after E33, with `done` = 1.
- Back in IDLE after E34.
- `busy` is high from the cycle after E0 through the DONE cycle, inclusive.
- Div-by-zero: HI/LO are written at E0. `done` pulses in the next cycle. `busy` is high that single cycle.
- A new `start` is accepted no earlier than the IDLE cycle following DONE.
- Latency is fixed and independent of operand values.

## Configuration
- `MULDIV_SIGNED_EN` defined:
  - Operands are two's complement and are converted to magnitudes at capture.
  - MUL: FIX negates the 2·WIDTH product when sign(a) ≠ sign(b).
  - DIV: quotient is negated when signs differ. Remainder takes the sign of the dividend.
  - -2^31 / -1 gives LO = 0x80000000, HI = 0.
- `MULDIV_SIGNED_EN` not defined:
  - Operands are unsigned. FIX passes values through unchanged.
  - Latency is identical, so the FIX state is kept.

## Structure
- Shared package `muldiv_pkg` holds:
  - Op/read codes: `OP_MULT`=1010, `OP_DIV`=1111, `OP_MFHI`=0101, `OP_MFLO`=0111.
  - FSM state typedef.
  - Default `WIDTH`.
- `muldiv_pkg` is also imported by the ALU control block.
- One sub-module, `muldiv_step`: combinational single-iteration datapath. Its mode input selects a shift-add or a trial-subtract/restore step.
- FSM, counter, sign handling and HI/LO live in `muldiv_sequencer`.

## Test plan
- mult 7 × 6 -> `done` 34 cycles after start; HI=0, LO=42. `stall` stays high on a concurrent `rd_en` until the DONE cycle.
- div 100 / 7 -> LO=14, HI=2. `mflo` after `done` gives `rd_data`=14.
- Signed build, mult 0xFFFFFFFD × 5 (-3×5) -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. Unsigned build: HI=4, LO=0xFFFFFFF1.
- div 0x1234 / 0 -> `done` the next cycle; LO=0xFFFFFFFF, HI=0x1234.
- Signed build, div -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Also 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- `reset_n` low at iteration 10 of a mult -> HI=LO=0, `busy`=0, no `done` pulse. Then issue a new start and check it completes normally.
